// File: rtl/rv32i_single_cycle_core_if.sv
// Instruction and data memory bus of the single-cycle RV32I core.
// The master side is the core; the slave side is the memory model.
interface rv32i_single_cycle_core_if;
   logic [31:0] o_pc;
   logic [31:0] i_inst;
   logic [31:0] i_mem;
   logic [31:0] o_addr;
   logic [31:0] o_mem;
   logic        o_write;
   logic        o_load;
   logic [1:0]  o_memsize;

   modport master (
      output o_pc, o_addr, o_mem, o_write, o_load, o_memsize,
      input  i_inst, i_mem
   );

   modport slave (
      input  o_pc, o_addr, o_mem, o_write, o_load, o_memsize,
      output i_inst, i_mem
   );
endinterface

// File: rtl/rv32i_single_cycle_core.sv
// Single-cycle RV32I core: decode, register file, ALU and PC.
// One instruction retires on every rising clock edge.
module rv32i_single_cycle_core #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input logic i_clk,
   input logic i_rst_n,
   rv32i_single_cycle_core_if.master bus
);

   logic [31:0] pc;
   logic [31:0] regs [32];

   logic [31:0] inst;
   logic [4:0]  opc;
   logic [4:0]  rd;
   logic [4:0]  rs1;
   logic [4:0]  rs2;
   logic [2:0]  f3;
   logic [31:0] rs1_v;
   logic [31:0] rs2_v;

   logic [31:0] imm_i;
   logic [31:0] imm_s;
   logic [31:0] imm_b;
   logic [31:0] imm_u;
   logic [31:0] imm_j;

   logic is_lui, is_auipc, is_jal, is_jalr;
   logic is_br, is_ld, is_st, is_opi, is_op;

   logic [31:0] alu_a;
   logic [31:0] alu_b;
   logic [31:0] alu_y;
   logic [31:0] pc4;
   logic [31:0] ld_v;
   logic [31:0] wd;
   logic        we;
   logic        take;
   logic [31:0] pc_nx;
   logic [1:0]  size;
   logic        st_ok;

   assign inst  = bus.i_inst;
   assign opc   = inst[6:2];
   assign rd    = inst[11:7];
   assign rs1   = inst[19:15];
   assign rs2   = inst[24:20];
   assign f3    = inst[14:12];
   assign rs1_v = (rs1 == 5'd0) ? 32'd0 : regs[rs1];
   assign rs2_v = (rs2 == 5'd0) ? 32'd0 : regs[rs2];

   assign imm_i = {{20{inst[31]}}, inst[31:20]};
   assign imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
   assign imm_b = {{19{inst[31]}}, inst[31], inst[7],
                   inst[30:25], inst[11:8], 1'b0};
   assign imm_u = {inst[31:12], 12'd0};
   assign imm_j = {{11{inst[31]}}, inst[31], inst[19:12],
                   inst[20], inst[30:21], 1'b0};

   assign is_lui   = (opc == 5'b01101);
   assign is_auipc = (opc == 5'b00101);
   assign is_jal   = (opc == 5'b11011);
   assign is_jalr  = (opc == 5'b11001);
   assign is_br    = (opc == 5'b11000);
   assign is_ld    = (opc == 5'b00000);
   assign is_st    = (opc == 5'b01000);
   assign is_opi   = (opc == 5'b00100);
   assign is_op    = (opc == 5'b01100);

   assign pc4 = pc + 32'd4;

   // Operand select: the adder also forms branch/jump targets.
   always_comb begin
      alu_a = rs1_v;
      alu_b = imm_i;
      unique case (1'b1)
         is_lui:   begin alu_a = 32'd0; alu_b = imm_u; end
         is_auipc: begin alu_a = pc;    alu_b = imm_u; end
         is_jal:   begin alu_a = pc;    alu_b = imm_j; end
         is_br:    begin alu_a = pc;    alu_b = imm_b; end
         is_st:    alu_b = imm_s;
         is_op:    alu_b = rs2_v;
         default:  alu_b = imm_i;
      endcase
   end

   // ALU: register ops use funct3, everything else is an add.
   always_comb begin
      alu_y = alu_a + alu_b;
      if (is_op || is_opi) begin
         unique case (f3)
            3'b000: alu_y = (is_op && inst[30]) ?
                            alu_a - alu_b : alu_a + alu_b;
            3'b001: alu_y = alu_a << alu_b[4:0];
            3'b010: alu_y = {31'd0,
                             $signed(alu_a) < $signed(alu_b)};
            3'b011: alu_y = {31'd0, alu_a < alu_b};
            3'b100: alu_y = alu_a ^ alu_b;
            3'b101: alu_y = inst[30] ?
                            32'($signed(alu_a) >>> alu_b[4:0]) :
                            alu_a >> alu_b[4:0];
            3'b110: alu_y = alu_a | alu_b;
            default: alu_y = alu_a & alu_b;
         endcase
      end
   end

   // Branch condition on the two source registers.
   always_comb begin
      unique case (f3)
         3'b000: take = (rs1_v == rs2_v);
         3'b001: take = (rs1_v != rs2_v);
         3'b100: take = $signed(rs1_v) < $signed(rs2_v);
         3'b101: take = $signed(rs1_v) >= $signed(rs2_v);
         3'b110: take = rs1_v < rs2_v;
         3'b111: take = rs1_v >= rs2_v;
         default: take = 1'b0;
      endcase
   end

   // Load data extension by access width.
   always_comb begin
      unique case (f3)
         3'b000: ld_v = {{24{bus.i_mem[7]}}, bus.i_mem[7:0]};
         3'b001: ld_v = {{16{bus.i_mem[15]}}, bus.i_mem[15:0]};
         3'b010: ld_v = bus.i_mem;
         3'b100: ld_v = {24'd0, bus.i_mem[7:0]};
         3'b101: ld_v = {16'd0, bus.i_mem[15:0]};
         default: ld_v = 32'd0;
      endcase
   end

   // Write-back value, write enable and next PC.
   always_comb begin
      wd    = alu_y;
      we    = 1'b0;
      pc_nx = pc4;
      unique case (1'b1)
         is_lui, is_auipc, is_op, is_opi: we = 1'b1;
         is_jal:  begin we = 1'b1; wd = pc4; pc_nx = alu_y; end
         is_jalr: begin
            we    = 1'b1;
            wd    = pc4;
            pc_nx = {alu_y[31:1], 1'b0};
         end
         is_br:   if (take) pc_nx = alu_y;
         is_ld:   begin we = 1'b1; wd = ld_v; end
         default: we = 1'b0;
      endcase
   end

   // Access size; unsupported widths report no access.
   always_comb begin
      size  = 2'b00;
      st_ok = 1'b0;
      if (is_ld || is_st) begin
         unique case (f3[1:0])
            2'b00:   size = 2'b01;
            2'b01:   size = 2'b10;
            2'b10:   size = 2'b11;
            default: size = 2'b00;
         endcase
         if (is_st && f3[2]) size = 2'b00;
         st_ok = is_st && (size != 2'b00);
      end
   end

   assign bus.o_pc      = pc;
   assign bus.o_addr    = alu_y;
   assign bus.o_mem     = rs2_v;
   assign bus.o_write   = st_ok && i_rst_n;
   assign bus.o_load    = is_ld && i_rst_n;
   assign bus.o_memsize = size;

   // Retire: PC and destination register update together.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         pc <= RESET_PC;
         for (int k = 0; k < 32; k++) regs[k] <= 32'd0;
      end else begin
         pc <= pc_nx;
         if (we && rd != 5'd0) regs[rd] <= wd;
      end
   end

endmodule

// File: tb/tb_rv32i_single_cycle_core.sv
// Directed self-checking bench for the single-cycle RV32I core.
// Registers are observed through ADD x0,rN,x0 on o_addr.
module tb_rv32i_single_cycle_core;

   logic clk;
   logic rst_n = 1'b1;
   int   checks = 0;
   int   failures = 0;

   rv32i_single_cycle_core_if bus ();

   rv32i_single_cycle_core #(.RESET_PC(32'h0)) dut (
      .i_clk  (clk),
      .i_rst_n(rst_n),
      .bus    (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   localparam logic [6:0] OP_LUI = 7'b0110111;
   localparam logic [6:0] OP_AUI = 7'b0010111;
   localparam logic [6:0] OP_JLR = 7'b1100111;
   localparam logic [6:0] OP_LD  = 7'b0000011;
   localparam logic [6:0] OP_OPI = 7'b0010011;
   localparam logic [6:0] OP_OP  = 7'b0110011;

   function automatic logic [31:0] enc_r(
      input logic [6:0] f7, input logic [4:0] r2,
      input logic [4:0] r1, input logic [2:0] f3,
      input logic [4:0] rd);
      return {f7, r2, r1, f3, rd, OP_OP};
   endfunction

   function automatic logic [31:0] enc_i(
      input logic [11:0] imm, input logic [4:0] r1,
      input logic [2:0] f3, input logic [4:0] rd,
      input logic [6:0] op);
      return {imm, r1, f3, rd, op};
   endfunction

   function automatic logic [31:0] enc_s(
      input logic [11:0] imm, input logic [4:0] r2,
      input logic [4:0] r1, input logic [2:0] f3);
      return {imm[11:5], r2, r1, f3, imm[4:0], 7'b0100011};
   endfunction

   function automatic logic [31:0] enc_b(
      input logic [12:0] imm, input logic [4:0] r2,
      input logic [4:0] r1, input logic [2:0] f3);
      return {imm[12], imm[10:5], r2, r1, f3,
              imm[4:1], imm[11], 7'b1100011};
   endfunction

   function automatic logic [31:0] enc_j(
      input logic [20:0] imm, input logic [4:0] rd);
      return {imm[20], imm[10:1], imm[11], imm[19:12],
              rd, 7'b1101111};
   endfunction

   task automatic step(input logic [31:0] ins);
      bus.i_inst = ins;
      @(posedge clk);
      #1;
   endtask

   task automatic peek(input logic [4:0] r, output logic [31:0] v);
      bus.i_inst = enc_r(7'd0, 5'd0, r, 3'b000, 5'd0);
      #1;
      v = bus.o_addr;
   endtask

   task automatic test_reset();
      logic [31:0] v;
      bus.i_inst = enc_i(12'd0, 5'd0, 3'b010, 5'd1, OP_LD);
      bus.i_mem  = 32'd0;
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (bus.o_pc !== 32'h0 || bus.o_load !== 1'b0) begin
         failures++;
         $display("FAIL reset_init pc=%h load=%b exp pc=0 load=0",
                  bus.o_pc, bus.o_load);
      end
      @(posedge clk);
      #1 rst_n = 1'b1;
      step(32'h0000_0013);
      step(32'h0000_0013);
      checks++;
      if (bus.o_pc !== 32'h8) begin
         failures++;
         $display("FAIL pre_reset_pc got=%h exp=8", bus.o_pc);
      end
      bus.i_inst = enc_s(12'd0, 5'd0, 5'd0, 3'b010);
      rst_n = 1'b0;
      #1;
      checks++;
      if (bus.o_pc !== 32'h0 || bus.o_write !== 1'b0) begin
         failures++;
         $display("FAIL midrun_reset pc=%h write=%b exp pc=0 write=0",
                  bus.o_pc, bus.o_write);
      end
      @(posedge clk);
      #1;
      checks++;
      if (bus.o_pc !== 32'h0) begin
         failures++;
         $display("FAIL reset_hold pc=%h exp=0", bus.o_pc);
      end
      rst_n = 1'b1;
      step(enc_i(12'd5, 5'd0, 3'b000, 5'd1, OP_OPI));
      step(enc_r(7'd0, 5'd1, 5'd1, 3'b000, 5'd2));
      checks++;
      if (bus.o_pc !== 32'h8) begin
         failures++;
         $display("FAIL after_reset_pc got=%h exp=8", bus.o_pc);
      end
      peek(5'd2, v);
      checks++;
      if (v !== 32'd10) begin
         failures++;
         $display("FAIL add_x2 got=%h exp=0000000a", v);
      end
   endtask

   task automatic test_arith();
      logic [31:0] v;
      step(enc_i(12'hFFF, 5'd0, 3'b000, 5'd3, OP_OPI));
      step(enc_i(12'h404, 5'd3, 3'b101, 5'd4, OP_OPI));
      step(enc_i(12'd28, 5'd3, 3'b101, 5'd5, OP_OPI));
      step(enc_r(7'd0, 5'd3, 5'd0, 3'b011, 5'd6));
      step(enc_r(7'd0, 5'd3, 5'd0, 3'b010, 5'd7));
      step(enc_i(12'd7, 5'd0, 3'b000, 5'd0, OP_OPI));
      peek(5'd4, v);
      checks++;
      if (v !== 32'hFFFF_FFFF) begin
         failures++;
         $display("FAIL srai got=%h exp=ffffffff", v);
      end
      peek(5'd5, v);
      checks++;
      if (v !== 32'hF) begin
         failures++;
         $display("FAIL srli got=%h exp=0000000f", v);
      end
      peek(5'd6, v);
      checks++;
      if (v !== 32'd1) begin
         failures++;
         $display("FAIL sltu got=%h exp=00000001", v);
      end
      peek(5'd7, v);
      checks++;
      if (v !== 32'd0) begin
         failures++;
         $display("FAIL slt got=%h exp=00000000", v);
      end
      peek(5'd0, v);
      checks++;
      if (v !== 32'd0) begin
         failures++;
         $display("FAIL x0_write got=%h exp=00000000", v);
      end
      bus.i_inst = enc_r(7'h20, 5'd5, 5'd0, 3'b000, 5'd10);
      #1;
      checks++;
      if (bus.o_addr !== 32'hFFFF_FFF1) begin
         failures++;
         $display("FAIL sub got=%h exp=fffffff1", bus.o_addr);
      end
   endtask

   task automatic test_upper();
      logic [31:0] v;
      checks++;
      if (bus.o_pc !== 32'h20) begin
         failures++;
         $display("FAIL auipc_pc got=%h exp=00000020", bus.o_pc);
      end
      step({20'h00001, 5'd9, OP_AUI});
      step({20'h12345, 5'd8, OP_LUI});
      peek(5'd8, v);
      checks++;
      if (v !== 32'h1234_5000) begin
         failures++;
         $display("FAIL lui got=%h exp=12345000", v);
      end
      peek(5'd9, v);
      checks++;
      if (v !== 32'h0000_1020) begin
         failures++;
         $display("FAIL auipc got=%h exp=00001020", v);
      end
   endtask

   task automatic test_mem();
      logic [31:0] v;
      step(enc_i(12'h100, 5'd0, 3'b000, 5'd1, OP_OPI));
      bus.i_inst = enc_s(12'd4, 5'd2, 5'd1, 3'b010);
      #1;
      checks++;
      if (bus.o_write !== 1'b1 || bus.o_addr !== 32'h104 ||
          bus.o_memsize !== 2'b11 || bus.o_mem !== 32'd10 ||
          bus.o_load !== 1'b0) begin
         failures++;
         $display("FAIL sw wr=%b addr=%h sz=%b data=%h ld=%b exp 1 104 11 0000000a 0",
                  bus.o_write, bus.o_addr, bus.o_memsize,
                  bus.o_mem, bus.o_load);
      end
      step(bus.i_inst);
      bus.i_mem = 32'h0000_80F0;
      bus.i_inst = enc_i(12'd0, 5'd1, 3'b000, 5'd11, OP_LD);
      #1;
      checks++;
      if (bus.o_load !== 1'b1 || bus.o_memsize !== 2'b01 ||
          bus.o_write !== 1'b0 || bus.o_addr !== 32'h100) begin
         failures++;
         $display("FAIL lb_strobe ld=%b sz=%b wr=%b addr=%h exp 1 01 0 100",
                  bus.o_load, bus.o_memsize, bus.o_write, bus.o_addr);
      end
      step(bus.i_inst);
      bus.i_inst = enc_i(12'd0, 5'd1, 3'b100, 5'd12, OP_LD);
      #1;
      checks++;
      if (bus.o_load !== 1'b1 || bus.o_memsize !== 2'b01) begin
         failures++;
         $display("FAIL lbu_strobe ld=%b sz=%b exp 1 01",
                  bus.o_load, bus.o_memsize);
      end
      step(bus.i_inst);
      bus.i_inst = enc_i(12'd0, 5'd1, 3'b001, 5'd13, OP_LD);
      #1;
      checks++;
      if (bus.o_load !== 1'b1 || bus.o_memsize !== 2'b10) begin
         failures++;
         $display("FAIL lh_strobe ld=%b sz=%b exp 1 10",
                  bus.o_load, bus.o_memsize);
      end
      step(bus.i_inst);
      step(enc_i(12'd0, 5'd1, 3'b010, 5'd14, OP_LD));
      bus.i_mem = 32'd0;
      peek(5'd11, v);
      checks++;
      if (v !== 32'hFFFF_FFF0) begin
         failures++;
         $display("FAIL lb got=%h exp=fffffff0", v);
      end
      peek(5'd12, v);
      checks++;
      if (v !== 32'h0000_00F0) begin
         failures++;
         $display("FAIL lbu got=%h exp=000000f0", v);
      end
      peek(5'd13, v);
      checks++;
      if (v !== 32'hFFFF_80F0) begin
         failures++;
         $display("FAIL lh got=%h exp=ffff80f0", v);
      end
      peek(5'd14, v);
      checks++;
      if (v !== 32'h0000_80F0) begin
         failures++;
         $display("FAIL lw got=%h exp=000080f0", v);
      end
   endtask

   task automatic test_branch();
      logic [31:0] exp_pc [4] = '{32'h50, 32'h44, 32'h50, 32'h44};
      logic [2:0]  f3s    [4] = '{3'b000, 3'b001, 3'b100, 3'b110};
      logic [4:0]  ra     [4] = '{5'd1, 5'd1, 5'd3, 5'd3};
      logic [4:0]  rb     [4] = '{5'd1, 5'd1, 5'd6, 5'd6};
      checks++;
      if (bus.o_pc !== 32'h40) begin
         failures++;
         $display("FAIL branch_start got=%h exp=00000040", bus.o_pc);
      end
      for (int n = 0; n < 4; n++) begin
         step(enc_b(13'd16, rb[n], ra[n], f3s[n]));
         checks++;
         if (bus.o_pc !== exp_pc[n]) begin
            failures++;
            $display("FAIL branch_%0d pc=%h exp=%h",
                     n, bus.o_pc, exp_pc[n]);
         end
         if (exp_pc[n] == 32'h50)
            step(enc_j(21'h1FFFF0, 5'd0));
         else
            step(enc_j(21'h1FFFFC, 5'd0));
      end
      checks++;
      if (bus.o_pc !== 32'h40) begin
         failures++;
         $display("FAIL jal_back got=%h exp=00000040", bus.o_pc);
      end
   endtask

   task automatic test_jump();
      logic [31:0] v;
      step(enc_j(21'h1FFFF8, 5'd1));
      checks++;
      if (bus.o_pc !== 32'h38) begin
         failures++;
         $display("FAIL jal_pc got=%h exp=00000038", bus.o_pc);
      end
      peek(5'd1, v);
      checks++;
      if (v !== 32'h44) begin
         failures++;
         $display("FAIL jal_link got=%h exp=00000044", v);
      end
      step(enc_i(12'h100, 5'd0, 3'b000, 5'd5, OP_OPI));
      step(enc_i(12'd3, 5'd5, 3'b000, 5'd2, OP_JLR));
      checks++;
      if (bus.o_pc !== 32'h102) begin
         failures++;
         $display("FAIL jalr_pc got=%h exp=00000102", bus.o_pc);
      end
      peek(5'd2, v);
      checks++;
      if (v !== 32'h40) begin
         failures++;
         $display("FAIL jalr_link got=%h exp=00000040", v);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] v;
      bus.i_inst = 32'h0000_0073;
      #1;
      checks++;
      if (bus.o_write !== 1'b0 || bus.o_load !== 1'b0 ||
          bus.o_memsize !== 2'b00) begin
         failures++;
         $display("FAIL system wr=%b ld=%b sz=%b exp 0 0 00",
                  bus.o_write, bus.o_load, bus.o_memsize);
      end
      step(bus.i_inst);
      checks++;
      if (bus.o_pc !== 32'h106) begin
         failures++;
         $display("FAIL system_pc got=%h exp=00000106", bus.o_pc);
      end
      step(enc_i(12'd1, 5'd1, 3'b000, 5'd1, OP_OPI));
      step(enc_i(12'd1, 5'd1, 3'b000, 5'd1, OP_OPI));
      peek(5'd1, v);
      checks++;
      if (v !== 32'h46) begin
         failures++;
         $display("FAIL b2b_addi got=%h exp=00000046", v);
      end
   endtask

   initial begin
      bus.i_inst = 32'h0000_0013;
      bus.i_mem  = 32'd0;
      test_reset();
      test_arith();
      test_upper();
      test_mem();
      test_branch();
      test_jump();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/rv32i_single_cycle_core.md
Name: rv32i_single_cycle_core

Overview:
- Single-cycle RV32I integer core: instruction decoder, 32x32 register file, ALU and program counter in one block.
- Sits between the instruction memory (driven by o_pc, returns i_inst combinationally) and the data memory (o_addr/o_mem/o_write/o_load/o_memsize, returns i_mem combinationally).
- One instruction retires per i_clk rising edge.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_inst  in  32  instruction at o_pc.
- i_mem  in  32  load data for o_addr (byte/half in low bits).
- o_pc  out  32  current PC, equal to the PC register.
- o_addr  out  32  data memory address.
- o_mem  out  32  store data (rs2 value).
- o_write  out  1  store strobe.
- o_load  out  1  load strobe.
- o_memsize  out  2  access size: 01 byte, 10 half, 11 word, 00 none.

Behaviour:
- Reset: asynchronous, active-low (i_rst_n low). PC = RESET_PC and x1..x31 = 0 immediately. While i_rst_n is low: o_write = 0, o_load = 0, no register write. First fetch after release is at RESET_PC.
- Register file: 2 combinational read ports (rs1 = inst[19:15], rs2 = inst[24:20]); 1 synchronous write port (rd = inst[11:7]). x0 always reads 0; writes to x0 are discarded. A same-cycle read of the rd being written returns the old value.
- Decode uses opcode inst[6:2]:
  - LUI 01101: rd = U-imm.
  - AUIPC 00101: rd = pc + U-imm.
  - JAL 11011: rd = pc+4; next pc = pc + J-imm.
  - JALR 11001: rd = pc+4; next pc = (rs1 + I-imm) with bit 0 cleared.
  - BRANCH 11000 (funct3): 000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU. Taken: next pc = pc + B-imm. Not taken, or funct3 010/011: pc+4.
  - LOAD 00000: o_load = 1, o_addr = rs1 + I-imm. funct3 000 LB, 001 LH, 010 LW (sign-extend i_mem[7:0]/[15:0]/full word); 100 LBU, 101 LHU (zero-extend); other funct3 write 0.
  - STORE 01000: o_write = 1, o_addr = rs1 + S-imm, o_mem = rs2. o_memsize from funct3: 000→01, 001→10, 010→11, others→00 (and o_write = 0).
  - OP-IMM 00100 / OP 01100: ADD/SUB (SUB only for OP with inst[30]), SLL, SLT, SLTU, XOR, SRL/SRA (inst[30]), OR, AND. Shift amount is the low 5 bits. Shift-immediate uses inst[24:20].
  - Any other opcode (FENCE, SYSTEM, illegal): no register write, no memory access, pc+4.
- Immediates are all sign-extended from inst[31]. B-imm and J-imm keep bit 0 = 0.
- o_memsize is 00 unless the instruction is a load or store. For loads it follows funct3[1:0] (00→01, 01→10, 10→11).
- o_addr equals the ALU result for non-memory instructions.
- Arithmetic wraps modulo 2^32; PC arithmetic wraps. No misalignment traps: the low address bits are passed to memory unchanged.
- Register write and PC update take effect on the same rising edge. Combinational outputs settle within the cycle.

Test Plan:
- Reset → i_rst_n low mid-run: o_pc = 0 immediately. After release, ADDI x1,x0,5 then ADD x2,x1,x1 → x2 = 10, o_pc = 8.
- Arithmetic edges → ADDI x3,x0,-1; SRAI x4,x3,4 → 0xFFFFFFFF; SRLI x5,x3,28 → 0xF. SLTU x6,x0,x3 → 1; SLT x7,x0,x3 → 0. ADDI x0,x0,7 leaves x0 = 0.
- LUI x8,0x12345; AUIPC x9,1 at pc=0x20 → x8 = 0x12345000, x9 = 0x1020.
- Loads/stores with x1=0x100, i_mem=0x0000_80F0:
  - SW x2,4(x1) → o_write = 1, o_addr = 0x104, o_memsize = 11, o_mem = x2.
  - LB → 0xFFFFFFF0; LBU → 0xF0; LH → 0xFFFF80F0.
  - o_load = 1 for each load.
- Branches from pc=0x40, offset +16:
  - BEQ equal → 0x50; BNE equal → 0x44.
  - BLT -1 vs 1 → taken; BLTU -1 vs 1 → not taken.
- JAL x1,-8 at 0x40 → pc = 0x38, x1 = 0x44. JALR x2,3(x5) with x5=0x100 → pc = 0x102, x2 = pc+4.
